pool_seq_ctrl: RTL and testbench

POOL_SEQ_CTRL -- requirements
Module: pool_seq_ctrl

---
 rtl/pool_seq_ctrl_pkg.sv | 25 ++
 rtl/pool_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_pool_seq_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pool_seq_ctrl_pkg.sv
// Shared pooling definitions: default geometry, sequencer state encoding and
// the expected-window-count helper used by pool_seq_ctrl.
package pool_seq_ctrl_pkg;

  localparam int POOL_K       = 2;
  localparam int POOL_IN_SIZE = 8;
  localparam int STRIDE       = 2;
  localparam int IF_BW        = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Windows emitted per channel by a K x K / stride-S line buffer.
  function automatic int expected_win_cnt(input int in_size, input int k, input int s);
    int side;
    side = (in_size - k) / s + 1;
    return side * side;
  endfunction

endpackage

// File: rtl/pool_seq_ctrl.sv
// Pooling job sequencer: walks CH_NUM channels through the line buffer and
// checks the window count per channel. POOL_SEQ_PERF_EN adds o_stall_cnt.
module pool_seq_ctrl #(
  parameter int IN_SIZE = pool_seq_ctrl_pkg::POOL_IN_SIZE,
  parameter int POOL_K  = pool_seq_ctrl_pkg::POOL_K,
  parameter int STRIDE  = pool_seq_ctrl_pkg::STRIDE,
  parameter int CH_NUM  = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_start,
  input  logic i_abort,
  input  logic i_src_valid,
  output logic o_src_ready,
  input  logic i_dst_ready,
  output logic o_lb_valid,
  output logic o_lb_clr,
  input  logic i_win_valid,
  output logic [$clog2(CH_NUM > 1 ? CH_NUM : 2)-1:0] o_ch_idx,
  output logic o_busy,
  output logic o_done,
  output logic o_err
`ifdef POOL_SEQ_PERF_EN
  ,
  output logic [31:0] o_stall_cnt
`endif
);

  import pool_seq_ctrl_pkg::*;

  localparam int PIX_NUM = IN_SIZE * IN_SIZE;
  localparam int PIX_W   = (PIX_NUM > 1) ? $clog2(PIX_NUM) : 1;
  localparam int CH_W    = $clog2(CH_NUM > 1 ? CH_NUM : 2);
  localparam int WIN_EXP = expected_win_cnt(IN_SIZE, POOL_K, STRIDE);
  // One spare bit so a saturated window count never aliases the expected value.
  localparam int WIN_W   = $clog2(PIX_NUM + 1) + 1;

  state_t             state_q, state_d;
  logic [PIX_W-1:0]   pix_cnt_q;
  logic [WIN_W-1:0]   win_cnt_q;
  logic [WIN_W-1:0]   win_next;
  logic [CH_W-1:0]    ch_idx_q;
  logic               err_q;

  logic handshake;
  logic last_pix;
  logic win_hit;
  logic start_acc;
  logic abort_go;
  logic last_ch;

  assign o_src_ready = (state_q == ST_STREAM) & i_dst_ready;
  assign o_lb_valid  = i_src_valid & o_src_ready;
  assign handshake   = o_lb_valid;
  assign last_pix    = handshake && (pix_cnt_q == PIX_W'(PIX_NUM - 1));
  assign start_acc   = (state_q == ST_IDLE) && i_start;
  assign abort_go    = (state_q != ST_IDLE) && i_abort;
  assign last_ch     = (ch_idx_q == CH_W'(CH_NUM - 1));
  assign win_hit     = i_win_valid && ((state_q == ST_STREAM) || (state_q == ST_FLUSH));
  assign win_next    = win_cnt_q + WIN_W'(win_hit && (win_cnt_q != '1));

  assign o_busy   = (state_q != ST_IDLE);
  assign o_lb_clr = (state_q == ST_CLEAR);
  assign o_done   = (state_q == ST_DONE);
  assign o_err    = err_q;
  assign o_ch_idx = ch_idx_q;

  // NOTE: state_d gets its hold value before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (i_start) state_d = ST_CLEAR;
      ST_CLEAR:  state_d = ST_STREAM;
      ST_STREAM: if (last_pix) state_d = ST_FLUSH;
      ST_FLUSH:  state_d = last_ch ? ST_DONE : ST_CLEAR;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    // Abort overrides everything, including a last-pixel handshake.
    if (abort_go) state_d = ST_IDLE;
  end

  // NOTE: every register here uses <= so all of them sample the pre-edge
  // values; a blocking = would let later statements see updated state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      pix_cnt_q <= '0;
      win_cnt_q <= '0;
      ch_idx_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;

      case (state_q)
        ST_CLEAR: begin
          pix_cnt_q <= '0;
          win_cnt_q <= '0;
        end
        ST_STREAM: begin
          if (handshake) pix_cnt_q <= pix_cnt_q + PIX_W'(1);
          win_cnt_q <= win_next;
        end
        ST_FLUSH: win_cnt_q <= win_next;
        default: ;
      endcase

      if (abort_go || (state_q == ST_DONE)) begin
        ch_idx_q <= '0;
      end else if ((state_q == ST_FLUSH) && !last_ch) begin
        ch_idx_q <= ch_idx_q + CH_W'(1);
      end

      if (start_acc) begin
        err_q <= 1'b0;
      end else if ((state_q == ST_FLUSH) && !i_abort && (win_next != WIN_W'(WIN_EXP))) begin
        err_q <= 1'b1;
      end
    end
  end

`ifdef POOL_SEQ_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else if (start_acc) begin
      stall_cnt_q <= '0;
    end else if ((state_q == ST_STREAM) && i_src_valid && !i_dst_ready &&
                 (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pool_seq_ctrl.sv
// Scoreboard bench for pool_seq_ctrl (IN_SIZE=4, K=2, S=2, CH_NUM=2); the
// stall counter is checked when POOL_SEQ_PERF_EN is defined.
module tb_pool_seq_ctrl;

  localparam int IN_SIZE = 4;
  localparam int POOL_K  = 2;
  localparam int STRIDE  = 2;
  localparam int CH_NUM  = 2;
  localparam int PIX_NUM = IN_SIZE * IN_SIZE;
  localparam int JOB_CYC = 37;

  logic clk         = 1'b0;
  logic reset_n     = 1'b0;
  logic i_start     = 1'b0;
  logic i_abort     = 1'b0;
  logic i_src_valid = 1'b0;
  logic i_dst_ready = 1'b0;
  logic i_win_valid = 1'b0;
  logic o_src_ready, o_lb_valid, o_lb_clr, o_busy, o_done, o_err;
  logic [0:0] o_ch_idx;
`ifdef POOL_SEQ_PERF_EN
  logic [31:0] o_stall_cnt;
`endif

  pool_seq_ctrl #(
    .IN_SIZE(IN_SIZE), .POOL_K(POOL_K), .STRIDE(STRIDE), .CH_NUM(CH_NUM)
  ) dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_abort(i_abort),
    .i_src_valid(i_src_valid), .o_src_ready(o_src_ready), .i_dst_ready(i_dst_ready),
    .o_lb_valid(o_lb_valid), .o_lb_clr(o_lb_clr), .i_win_valid(i_win_valid),
    .o_ch_idx(o_ch_idx), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
`ifdef POOL_SEQ_PERF_EN
    , .o_stall_cnt(o_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef enum int {EV_CLR = 0, EV_PIX = 1, EV_DONE = 2} ev_t;
  typedef struct {
    ev_t kind;
    int  ch;
    int  err;
    int  cyc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  int mon_pix     = 0;
  bit in_stream   = 1'b0;
  int stall_model = 0;
  bit win_pend    = 1'b0;
  bit drop_ch0    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line-buffer stub: pixel p closes a window when its row and column are
  // both window bottom/right edges.
  function automatic bit closes_window(input int p);
    int row, col;
    row = p / IN_SIZE;
    col = p % IN_SIZE;
    return (row >= POOL_K - 1) && ((row - (POOL_K - 1)) % STRIDE == 0) &&
           (col >= POOL_K - 1) && ((col - (POOL_K - 1)) % STRIDE == 0);
  endfunction

  task automatic push_ev(input ev_t kind, input int ch, input int err, input int c);
    exp_t e;
    e.kind = kind;
    e.ch   = ch;
    e.err  = err;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic push_job(input int start_cyc, input bit drop, input bit timed);
    for (int ch = 0; ch < CH_NUM; ch++) begin
      push_ev(EV_CLR, ch, (drop && ch > 0) ? 1 : 0, -1);
      for (int p = 0; p < PIX_NUM; p++) push_ev(EV_PIX, ch, (drop && ch > 0) ? 1 : 0, -1);
    end
    push_ev(EV_DONE, 0, drop ? 1 : 0, timed ? start_cyc + JOB_CYC : -1);
  endtask

  // Monitor: pops one expectation per presented event, and models the stub
  // window returns and stall count.
  initial begin
    exp_t e;
    ev_t  act_kind;
    bit   is_ev;
    forever begin
      @(negedge clk);
      if (in_stream && i_src_valid && !i_dst_ready) stall_model++;
      i_win_valid = win_pend;
      win_pend = 1'b0;
      is_ev = 1'b1;
      act_kind = EV_DONE;
      if (o_lb_clr)        act_kind = EV_CLR;
      else if (o_lb_valid) act_kind = EV_PIX;
      else if (!o_done)    is_ev = 1'b0;
      if (is_ev) begin
        check("sb_has_entry", longint'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("ev_kind", longint'(act_kind), longint'(e.kind));
          if (act_kind == e.kind) begin
            if (e.kind != EV_DONE) check("ev_ch_idx", o_ch_idx, e.ch);
            check("ev_err", o_err, e.err);
            if (e.cyc >= 0) check("done_cycle", cyc, e.cyc);
          end
        end
      end
      if (o_lb_clr) begin
        in_stream = 1'b1;
        mon_pix   = 0;
      end
      if (o_lb_valid) begin
        if (closes_window(mon_pix) && !(drop_ch0 && o_ch_idx == 1'b0 && mon_pix == 5))
          win_pend = 1'b1;
        mon_pix++;
        if (mon_pix == PIX_NUM) in_stream = 1'b0;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (o_done) break;
    end
    check("done_seen", o_done, 1);
    @(negedge clk);
    check("sb_drained", sb.size(), 0);
  endtask

  task automatic run_job(input bit drop, input bit timed);
    tick;
    i_start = 1'b1;
    stall_model = 0;
    push_job(cyc, drop, timed);
    tick;
    i_start = 1'b0;
    wait_done(200);
  endtask

  initial begin
    int c, n, k, dones;

    // Reset state
    i_src_valid = 1'b1;
    i_dst_ready = 1'b1;
    repeat (3) tick;
    @(negedge clk);
    check("rst_src_ready", o_src_ready, 0);
    check("rst_lb_valid", o_lb_valid, 0);
    check("rst_lb_clr", o_lb_clr, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_err", o_err, 0);
    check("rst_ch_idx", o_ch_idx, 0);
`ifdef POOL_SEQ_PERF_EN
    check("rst_stall_cnt", o_stall_cnt, 0);
`endif
    tick;
    reset_n = 1'b1;

    // Continuous valid/ready: done exactly 37 cycles after start
    run_job(1'b0, 1'b1);
    check("job1_err", o_err, 0);

    // Ready toggling every cycle
    tick;
    i_start = 1'b1;
    stall_model = 0;
    push_job(cyc, 1'b0, 1'b0);
    tick;
    i_start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick;
      i_dst_ready = ~i_dst_ready;
      @(negedge clk);
      if (!i_dst_ready) begin
        check("hold_src_ready", o_src_ready, 0);
        check("hold_lb_valid", o_lb_valid, 0);
      end
      if (o_done) break;
    end
    check("toggle_done_seen", o_done, 1);
    @(negedge clk);
    check("toggle_sb_drained", sb.size(), 0);
`ifdef POOL_SEQ_PERF_EN
    check("stall_cnt", o_stall_cnt, stall_model);
`endif
    tick;
    i_dst_ready = 1'b1;

    // Window-count mismatch on channel 0, then cleared by the next start
    drop_ch0 = 1'b1;
    run_job(1'b1, 1'b1);
    drop_ch0 = 1'b0;
    @(negedge clk);
    check("err_sticky", o_err, 1);
    run_job(1'b0, 1'b1);

    // Abort on pixel 15 of channel 1
    tick;
    i_start = 1'b1;
    push_job(cyc, 1'b0, 1'b0);
    void'(sb.pop_back());
    tick;
    i_start = 1'b0;
    n = 0;
    k = 0;
    while (n < PIX_NUM - 1 && k < 100) begin
      @(negedge clk);
      if (o_lb_valid && o_ch_idx == 1'b1) n++;
      k++;
    end
    check("abort_reach_pix14", n, PIX_NUM - 1);
    tick;
    i_abort = 1'b1;
    tick;
    i_abort = 1'b0;
    @(negedge clk);
    check("abort_busy", o_busy, 0);
    check("abort_ch_idx", o_ch_idx, 0);
    check("abort_done", o_done, 0);
    dones = 0;
    repeat (45) begin
      @(negedge clk);
      if (o_done) dones++;
    end
    check("abort_no_done", dones, 0);
    check("abort_sb_drained", sb.size(), 0);

    // One-cycle reset pulse during STREAM of channel 0
    tick;
    i_start = 1'b1;
    push_ev(EV_CLR, 0, 0, -1);
    for (int p = 0; p < 4; p++) push_ev(EV_PIX, 0, 0, -1);
    tick;
    i_start = 1'b0;
    repeat (4) tick;
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_src_ready", o_src_ready, 0);
    check("mid_rst_lb_valid", o_lb_valid, 0);
    check("mid_rst_lb_clr", o_lb_clr, 0);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_done", o_done, 0);
    check("mid_rst_err", o_err, 0);
    check("mid_rst_ch_idx", o_ch_idx, 0);
    check("mid_rst_sb_drained", sb.size(), 0);
    tick;
    reset_n = 1'b1;
    run_job(1'b0, 1'b1);

    // i_start held through a whole job: second job only after IDLE
    tick;
    i_start = 1'b1;
    c = cyc;
    push_job(c, 1'b0, 1'b1);
    push_job(c + JOB_CYC + 1, 1'b0, 1'b1);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (o_done) break;
    end
    check("held_done1_seen", o_done, 1);
    @(negedge clk);
    check("held_idle_between", o_busy, 0);
    tick;
    @(negedge clk);
    check("held_restart_busy", o_busy, 1);
    check("held_restart_clr", o_lb_clr, 1);
    tick;
    i_start = 1'b0;
    wait_done(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
